serial_alu_ctrl: RTL

Bit-serial sequencer that executes WIDTH-bit operations on the shared 1-bit ALU.
- Latches two WIDTH-bit operands and a 4-bit op field on a start handshake.
- Presents one bit pair per cycle to the ALU, LSB first, on the ALU's 6-bit opcode bus {op[3:0], a_bit, b_bit}.
- Chains carry between cycles and assembles the WIDTH-bit result and flags.
- Sits between the register-file/control path and the 1-bit ALU instance.

---
 rtl/serial_alu_pkg.sv | 41 ++++
 rtl/serial_alu_ctrl_if.sv | 59 +++++
 rtl/serial_shreg.sv | 25 ++
 rtl/serial_alu_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: op codes, FSM states and op helpers
// shared by the bit-serial ALU sequencer.
package serial_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(
    input logic [3:0] op
  );
    case (op)
      OP_AND, OP_OR, OP_ADD,
      OP_SUB, OP_NOR, OP_NAND: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_arith(
    input logic [3:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // SUB runs on the ALU's add path with B inverted
  function automatic logic [3:0] alu_op(
    input logic [3:0] op
  );
    return (op == OP_SUB) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// serial_alu_ctrl_if: request/result bundle plus the 1-bit ALU link.
// overflow is present only when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             slt;
  logic             illegal_op;
`ifdef SERIAL_ALU_OVF_EN
  logic             overflow;
`endif
  logic [5:0]       alu_opcode;
  logic             alu_result;
  logic             alu_carry;

`ifdef SERIAL_ALU_OVF_EN
  modport master (
    output start, op, opa, opb,
    output alu_result, alu_carry,
    input  ready, busy, done, result,
    input  carry_out, zero, slt,
    input  illegal_op, overflow,
    input  alu_opcode
  );
  modport slave (
    input  start, op, opa, opb,
    input  alu_result, alu_carry,
    output ready, busy, done, result,
    output carry_out, zero, slt,
    output illegal_op, overflow,
    output alu_opcode
  );
`else
  modport master (
    output start, op, opa, opb,
    output alu_result, alu_carry,
    input  ready, busy, done, result,
    input  carry_out, zero, slt,
    input  illegal_op, alu_opcode
  );
  modport slave (
    input  start, op, opa, opb,
    input  alu_result, alu_carry,
    output ready, busy, done, result,
    output carry_out, zero, slt,
    output illegal_op, alu_opcode
  );
`endif

endinterface

// File: rtl/serial_shreg.sv
// serial_shreg: right-shift register with parallel load
// and serial input at the MSB.
module serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: runs WIDTH-bit ops LSB first on a 1-bit ALU.
// Define SERIAL_ALU_OVF_EN to expose the overflow output.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              reset,
  serial_alu_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic [3:0]       op_q;
  logic             arith_q;
  logic             sub_q;

  logic             ld;
  logic             run_en;
  logic             sub_in;
  logic [WIDTH-1:0] b_ld;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] res_full;
  logic             bit_s;
  logic             c_nxt;
  logic             ovf;
  logic             unused_lsb;

  assign ld     = (state == IDLE) && bus.start;
  assign run_en = (state == RUN);
  assign sub_in = (bus.op == OP_SUB);
  assign b_ld   = sub_in ? ~bus.opb : bus.opb;

  // ALU only half-adds; the carry is folded in here
  always_comb begin
    bit_s = bus.alu_result;
    c_nxt = 1'b0;
    if (arith_q) begin
      bit_s = bus.alu_result ^ c;
      c_nxt = bus.alu_carry |
              (bus.alu_result & c);
    end
  end

  assign res_full   = {bit_s, r_q[WIDTH-1:1]};
  assign ovf        = arith_q & (c ^ c_nxt);
  assign unused_lsb = ^{a_q[0], b_q[0], r_q[0]};

  serial_shreg #(.WIDTH(WIDTH)) u_a (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .shift (run_en),
    .sin   (1'b0),
    .din   (bus.opa),
    .q     (a_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .shift (run_en),
    .sin   (1'b0),
    .din   (b_ld),
    .q     (b_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_r (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .shift (run_en),
    .sin   (bit_s),
    .din   ('0),
    .q     (r_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      c              <= 1'b0;
      op_q           <= '0;
      arith_q        <= 1'b0;
      sub_q          <= 1'b0;
      bus.ready      <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.result     <= '0;
      bus.carry_out  <= 1'b0;
      bus.zero       <= 1'b0;
      bus.slt        <= 1'b0;
      bus.illegal_op <= 1'b0;
      bus.alu_opcode <= '0;
`ifdef SERIAL_ALU_OVF_EN
      bus.overflow   <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt           <= '0;
            bus.ready     <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.zero      <= 1'b0;
            bus.slt       <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            bus.overflow  <= 1'b0;
`endif
            if (is_legal_op(bus.op)) begin
              state          <= RUN;
              bus.busy       <= 1'b1;
              bus.illegal_op <= 1'b0;
              op_q           <= alu_op(bus.op);
              arith_q        <= is_arith(bus.op);
              sub_q          <= sub_in;
              c              <= sub_in;
              bus.alu_opcode <= {alu_op(bus.op),
                                 bus.opa[0], b_ld[0]};
            end else begin
              // result stays 0, so zero reads as set
              state          <= DONE;
              bus.illegal_op <= 1'b1;
              bus.zero       <= 1'b1;
              bus.done       <= 1'b1;
            end
          end
        end
        RUN: begin
          c              <= c_nxt;
          cnt            <= cnt + 1'b1;
          bus.alu_opcode <= {op_q, a_q[1], b_q[1]};
          if (cnt == LAST) begin
            state          <= DONE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            bus.alu_opcode <= '0;
            bus.result     <= res_full;
            bus.zero       <= (res_full == '0);
            bus.carry_out  <= c_nxt;
            bus.slt        <= sub_q & (bit_s ^ ovf);
`ifdef SERIAL_ALU_OVF_EN
            bus.overflow   <= ovf;
`endif
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
